// File: rtl/multisync_lock_pkg.sv
// Shared types and default parameters for the multi-lane sync-position qualifier.
// Lane state encoding is fixed so downstream deskew logic can decode it directly.
package multisync_lock_pkg;

    localparam int unsigned DEF_NCHAN        = 3;
    localparam int unsigned DEF_NBITS        = 16;
    localparam int unsigned DEF_QUALITY_BITS = 3;
    localparam int unsigned DEF_TOLERANCE    = 0;
    localparam int unsigned DEF_TIMEOUT      = 0;
    localparam int unsigned DEF_OPT_HOLD     = 0;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/synclock_chan.sv
// One lane of the sync qualifier: observation register, confidence counter with
// optional idle timeout, and the SEARCH/LOCKED state machine with registered outputs.
module synclock_chan
    import multisync_lock_pkg::*;
#(
    parameter int unsigned NBITS        = DEF_NBITS,
    parameter int unsigned QUALITY_BITS = DEF_QUALITY_BITS,
    parameter int unsigned TOLERANCE    = DEF_TOLERANCE,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned OPT_HOLD     = DEF_OPT_HOLD
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_v,
    input  logic [NBITS-1:0] i_val,
    output logic [NBITS-1:0] o_val,
    output logic             o_locked,
    output logic             o_lost
);

    localparam logic [QUALITY_BITS-1:0] MAX_COUNT = '1;
    localparam logic [NBITS:0]          TOL       = (NBITS+1)'(TOLERANCE);

    logic                    r_v;
    logic [NBITS-1:0]        r_in;
    logic                    r_match;
    logic [NBITS-1:0]        r_cand;
    logic [QUALITY_BITS-1:0] r_ngood;
    lock_state_e             r_state;

    logic                    w_seed;
    logic                    w_expire;
    logic [NBITS-1:0]        w_cand_next;
    logic [NBITS:0]          w_a;
    logic [NBITS:0]          w_b;
    logic [NBITS:0]          w_diff;

    // The candidate being seeded this cycle is forwarded so a back-to-back strobe
    // is compared against the new candidate rather than the stale one.
    assign w_seed      = r_v && (r_ngood == '0);
    assign w_cand_next = w_seed ? r_in : r_cand;

    // One extra bit keeps the distance unsigned with no modular wrap.
    assign w_a    = {1'b0, i_val};
    assign w_b    = {1'b0, w_cand_next};
    assign w_diff = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);

    // NOTE: every register here uses <= so all stages sample pre-edge values together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v     <= 1'b0;
            r_in    <= '0;
            r_match <= 1'b0;
        end else begin
            r_v     <= i_v;
            r_in    <= i_val;
            r_match <= (w_diff <= TOL);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int unsigned TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] r_timer;

            assign w_expire = !r_v && (r_timer == TW'(TIMEOUT - 1));

            always_ff @(posedge i_clk) begin
                if (i_reset || r_v || w_expire) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end else begin : g_no_timer
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cand  <= '0;
            r_ngood <= '0;
        end else if (w_seed) begin
            r_cand  <= r_in;
            r_ngood <= QUALITY_BITS'(1);
        end else if (r_v && r_match) begin
            if (r_ngood != MAX_COUNT) begin
                r_ngood <= r_ngood + 1'b1;
            end
        end else if (r_v) begin
            r_ngood <= r_ngood - 1'b1;
        end else if (w_expire && (r_ngood != '0)) begin
            r_ngood <= r_ngood - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= SEARCH;
            o_val    <= '0;
            o_locked <= 1'b0;
            o_lost   <= 1'b0;
        end else begin
            o_lost <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (r_ngood == MAX_COUNT) begin
                        r_state  <= LOCKED;
                        o_locked <= 1'b1;
                        o_val    <= r_cand;
                    end
                end
                LOCKED: begin
                    if (r_ngood == '0) begin
                        r_state  <= SEARCH;
                        o_locked <= 1'b0;
                        o_lost   <= 1'b1;
                        if (OPT_HOLD == 0) begin
                            o_val <= '0;
                        end
                    end else begin
                        o_val <= r_cand;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    o_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multisync_lock.sv
// Multi-lane sync-position qualifier: NCHAN independent lane qualifiers plus a
// registered all-lanes-locked summary for the deskew controller.
module multisync_lock
    import multisync_lock_pkg::*;
#(
    parameter int unsigned NCHAN        = DEF_NCHAN,
    parameter int unsigned NBITS        = DEF_NBITS,
    parameter int unsigned QUALITY_BITS = DEF_QUALITY_BITS,
    parameter int unsigned TOLERANCE    = DEF_TOLERANCE,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned OPT_HOLD     = DEF_OPT_HOLD
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NCHAN-1:0]       i_v,
    input  logic [NCHAN*NBITS-1:0] i_val,
    output logic [NCHAN*NBITS-1:0] o_val,
    output logic [NCHAN-1:0]       o_locked,
    output logic                   o_all_locked,
    output logic [NCHAN-1:0]       o_lost
);

    generate
        for (genvar k = 0; k < NCHAN; k++) begin : g_lane
            synclock_chan #(
                .NBITS        (NBITS),
                .QUALITY_BITS (QUALITY_BITS),
                .TOLERANCE    (TOLERANCE),
                .TIMEOUT      (TIMEOUT),
                .OPT_HOLD     (OPT_HOLD)
            ) u_chan (
                .i_clk    (i_clk),
                .i_reset  (i_reset),
                .i_v      (i_v[k]),
                .i_val    (i_val[k*NBITS +: NBITS]),
                .o_val    (o_val[k*NBITS +: NBITS]),
                .o_locked (o_locked[k]),
                .o_lost   (o_lost[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_all_locked <= 1'b0;
        end else begin
            o_all_locked <= &o_locked;
        end
    end

endmodule
